// File: rtl/data_table_reader_if.sv
// Bundle of the data table reader's command, RAM read and stream signals.
// Ports (grouped):
//   cmd_valid/cmd_ready/cmd_addr/cmd_len  read command handshake
//   rd_addr/rd_data                       RAM read port (1-cycle latency)
//   m_valid/m_ready/m_data/m_last         output word stream
//   busy/done                             command status
// master: the reader; slave: command source, RAM and stream consumer.
interface data_table_reader_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 38,
  parameter int LEN_WIDTH  = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  busy;
  logic                  done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, rd_data, m_ready,
    output cmd_ready, rd_addr, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, rd_data, m_ready,
    input  cmd_ready, rd_addr, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/data_table_reader.sv
// Read-side sequencer for the data table RAM. Takes a (start address, length)
// command, issues sequential read addresses (wrapping at the table end), soaks up
// the 1-cycle RAM latency in a 2-entry skid buffer and streams words out with
// m_last on the final word.
// Ports:
//   rd_clk  single clock (RAM read clock)
//   rd_rst  asynchronous active-high reset
//   bus     data_table_reader_if.master (command, RAM read port, stream, status)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// READ  | issuing read addresses while buffer room allows
// DRAIN | all addresses issued, emptying buffer until the last word
// DONE  | one-cycle done pulse, then back to IDLE
module data_table_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 38,
  parameter int LEN_WIDTH  = 10
) (
  input logic                 rd_clk,
  input logic                 rd_rst,
  data_table_reader_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  pend_q, pend_d;
  logic                  pend_last_q, pend_last_d;

  logic [1:0][DATA_WIDTH-1:0] buf_data_q;
  logic [1:0]                 buf_last_q;
  logic                       wr_ptr_q;
  logic                       rd_ptr_q;
  logic [1:0]                 count_q;

  logic       m_valid;
  logic       m_last;
  logic       pop;
  logic [2:0] occ;

  assign m_valid       = (count_q != 2'd0);
  assign m_last        = m_valid & buf_last_q[rd_ptr_q];
  assign bus.m_valid   = m_valid;
  assign bus.m_last    = m_last;
  assign bus.m_data    = buf_data_q[rd_ptr_q];
  assign bus.rd_addr   = addr_q;
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_READ) || (state_q == S_DRAIN);
  assign bus.done      = (state_q == S_DONE);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    pend_d      = 1'b0;
    pend_last_d = 1'b0;
    pop         = m_valid & bus.m_ready;
    // Occupancy the buffer will have once the in-flight read lands and the
    // current pop retires; a new read may only be issued if it leaves room.
    occ         = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop};

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          rem_d   = bus.cmd_len;
          state_d = (bus.cmd_len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (occ < 3'd2) begin
          pend_d      = 1'b1;
          pend_last_d = (rem_q == LEN_WIDTH'(1));
          addr_d      = addr_q + ADDR_WIDTH'(1);
          rem_d       = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && m_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Skid buffer: the word read in the previous cycle is captured together with
  // its last tag; m_data always shows the head entry.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      buf_data_q <= '0;
      buf_last_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      if (pend_q) begin
        buf_data_q[wr_ptr_q] <= bus.rd_data;
        buf_last_q[wr_ptr_q] <= pend_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, pend_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_data_table_reader.sv
module tb_data_table_reader;

  logic clk;
  logic rst;
  logic [37:0] mem [512];
  int n_chk;
  int n_pass;

  data_table_reader_if #(.ADDR_WIDTH(9), .DATA_WIDTH(38), .LEN_WIDTH(10)) bus ();

  data_table_reader #(.ADDR_WIDTH(9), .DATA_WIDTH(38), .LEN_WIDTH(10)) dut (
    .rd_clk (clk),
    .rd_rst (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM behaviour: data for the address sampled at an edge
  // is visible during the following cycle.
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string where);
    chk_val({where, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
    chk_val({where, "_rd_addr"},   64'(bus.rd_addr),   64'(0));
    chk_val({where, "_m_valid"},   64'(bus.m_valid),   64'(0));
    chk_val({where, "_m_data"},    64'(bus.m_data),    64'(0));
    chk_val({where, "_m_last"},    64'(bus.m_last),    64'(0));
    chk_val({where, "_busy"},      64'(bus.busy),      64'(0));
    chk_val({where, "_done"},      64'(bus.done),      64'(0));
  endtask

  // mode 0: m_ready always high, 1: toggles 1/0 each cycle, 2: random.
  // hold_next keeps cmd_valid high with a second command while busy.
  task automatic run_cmd(input logic [8:0] addr, input int len, input int mode,
                         input bit hold_next, input logic [8:0] nxt_addr, input int nxt_len);
    logic [37:0] exp_data[$];
    bit          exp_last[$];
    int          cyc, words, last_hs, first_v;
    bit          done_seen, prev_stall, prev_last;
    logic [37:0] prev_data;

    for (int i = 0; i < len; i++) begin
      exp_data.push_back(mem[(int'(addr) + i) % 512]);
      exp_last.push_back(i == len - 1);
    end

    chk_val("cmd_ready_idle", 64'(bus.cmd_ready), 64'(1));
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_len   = 10'(len);
    next_cycle();
    cyc = 1;
    chk_val("busy_after_accept", 64'(bus.busy), 64'(len != 0));
    if (len != 0) chk_val("rd_addr_first", 64'(bus.rd_addr), 64'(addr));
    if (hold_next) begin
      bus.cmd_addr = nxt_addr;
      bus.cmd_len  = 10'(nxt_len);
    end else begin
      bus.cmd_valid = 1'b0;
    end

    words = 0; last_hs = 0; first_v = -1;
    done_seen = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    while (!done_seen && cyc < 3000) begin
      case (mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = (cyc % 2 == 1);
        default: bus.m_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (prev_stall) begin
        chk_val("stall_valid", 64'(bus.m_valid), 64'(1));
        chk_val("stall_data",  64'(bus.m_data),  64'(prev_data));
        chk_val("stall_last",  64'(bus.m_last),  64'(prev_last));
      end
      if (bus.done) begin
        done_seen = 1'b1;
        chk_val("done_cycle", 64'(cyc), 64'((len == 0) ? 1 : last_hs + 1));
        chk_val("done_busy", 64'(bus.busy), 64'(0));
        chk_val("done_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        chk_val("word_count", 64'(words), 64'(len));
      end else begin
        if (bus.m_valid && first_v < 0) begin
          first_v = cyc;
          chk_val("first_valid_cycle", 64'(cyc), 64'(3));
        end
        if (bus.m_valid && bus.m_ready) begin
          if (exp_data.size() == 0) begin
            chk_val("extra_word", 64'(bus.m_data), 64'(0));
          end else begin
            chk_val("m_data", 64'(bus.m_data), 64'(exp_data.pop_front()));
            chk_val("m_last", 64'(bus.m_last), 64'(exp_last.pop_front()));
            if (mode == 0) chk_val("hs_cycle", 64'(cyc), 64'(3 + words));
          end
          words++;
          last_hs = cyc;
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
        next_cycle();
        cyc++;
      end
    end
    if (!done_seen) chk_val("timeout_done", 64'(0), 64'(1));
    next_cycle();
    chk_val("cmd_ready_after_done", 64'(bus.cmd_ready), 64'(1));
    chk_val("busy_after_done", 64'(bus.busy), 64'(0));
    chk_val("done_single_pulse", 64'(bus.done), 64'(0));
  endtask

  task automatic run_reset_test(input logic [8:0] addr);
    int words, cyc;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_len   = 10'd16;
    bus.m_ready   = 1'b1;
    next_cycle();
    bus.cmd_valid = 1'b0;
    words = 0; cyc = 0;
    while (words < 3 && cyc < 50) begin
      if (bus.m_valid && bus.m_ready) begin
        chk_val("rst_pre_data", 64'(bus.m_data), 64'(mem[(int'(addr) + words) % 512]));
        words++;
      end
      next_cycle();
      cyc++;
    end
    if (words < 3) chk_val("timeout_rst_words", 64'(words), 64'(3));
    chk_val("rst_busy_before", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      next_cycle();
      chk_val("post_rst_no_done", 64'(bus.done), 64'(0));
      chk_val("post_rst_no_valid", 64'(bus.m_valid), 64'(0));
    end
    chk_val("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.m_ready   = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = {29'($urandom), 9'(i)};
    #3;
    chk_reset_outputs("reset");
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();

    run_cmd(9'h010, 4, 0, 1'b0, 9'h0, 0);
    run_cmd(9'h1FE, 4, 0, 1'b0, 9'h0, 0);
    run_cmd(9'($urandom_range(0, 511)), 8, 1, 1'b0, 9'h0, 0);
    run_cmd(9'($urandom_range(0, 511)), 0, 0, 1'b0, 9'h0, 0);
    run_reset_test(9'($urandom_range(0, 511)));
    run_cmd(9'h100, 5, 2, 1'b1, 9'h0A0, 6);
    run_cmd(9'h0A0, 6, 0, 1'b0, 9'h0, 0);
    run_cmd(9'h000, 512, 0, 1'b0, 9'h0, 0);

    for (int k = 0; k < 12; k++) begin
      int a, l, m;
      a = $urandom_range(0, 511);
      l = ($urandom_range(0, 9) == 0) ? 512 : $urandom_range(0, 20);
      m = $urandom_range(0, 2);
      run_cmd(9'(a), l, m, 1'b0, 9'h0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
